// File: rtl/cargador_programa.sv
// Program loader: packs UART bytes MSB-first into words and writes them to
// consecutive instruction-memory addresses until the halt word or the last address.
module cargador_programa #(
  parameter int unsigned     len       = 32,
  parameter int unsigned     DEPTH     = 256,
  parameter logic [len-1:0]  HALT_WORD = '1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [7:0]     rx_data,
  input  logic           rx_done,
  output logic [len-1:0] wr_addr,
  output logic [len-1:0] wr_data,
  output logic           wr_en,
  output logic [len-1:0] word_count,
  output logic           done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DONE
  } state_t;

  localparam logic [len-1:0] LAST_ADDR = len'(DEPTH - 1);

  state_t          r_state;
  logic [1:0]      r_byte_cnt;
  logic [len-9:0]  r_shift;
  logic            w_last_write;

  // The write in flight ends the load: a byte arriving alongside it is dropped.
  assign w_last_write = wr_en && ((wr_data == HALT_WORD) || (wr_addr == LAST_ADDR));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      word_count <= '0;
      done       <= 1'b0;
    end else if (start) begin
      r_state    <= S_RECV;
      r_byte_cnt <= '0;
      wr_addr    <= '0;
      wr_en      <= 1'b0;
      word_count <= '0;
      done       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (r_state)
        S_RECV: begin
          if (wr_en) begin
            word_count <= word_count + 1'b1;
            if (w_last_write) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
          // A byte during wr_en is byte 0 of the next word, so a new write
          // can never be issued back to back with the current one.
          if (rx_done && !w_last_write) begin
            r_shift <= {r_shift[len-17:0], rx_data};
            if (r_byte_cnt == 2'd3) begin
              wr_data    <= {r_shift, rx_data};
              wr_en      <= 1'b1;
              r_byte_cnt <= '0;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
